// File: rtl/pdp8_ma_pkg.sv
// Shared types for the PDP-8/e memory-address unit: word/field types,
// major-state encodings and MRI opcodes.
package pdp8_ma_pkg;

  localparam int unsigned WORD_W    = 12;
  localparam int unsigned FIELD_W   = 3;
  localparam int unsigned ADDR_W    = FIELD_W + WORD_W;
  localparam int unsigned MEM_WORDS = 32768;

  // Bit 0 is the MSB throughout, matching PDP-8 documentation.
  typedef logic [0:WORD_W-1]  word_t;
  typedef logic [0:FIELD_W-1] field_t;
  typedef logic [0:ADDR_W-1]  maddr_t;

  typedef enum logic [3:0] {
    F0 = 4'd0,  F1 = 4'd1,  F2 = 4'd2,  F3 = 4'd3,
    D0 = 4'd4,  D1 = 4'd5,  D2 = 4'd6,  D3 = 4'd7,
    E0 = 4'd8,  E1 = 4'd9,  E2 = 4'd10, E3 = 4'd11,
    H0 = 4'd12, H1 = 4'd13, H2 = 4'd14, H3 = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    GRP_F = 2'd0,
    GRP_D = 2'd1,
    GRP_E = 2'd2,
    GRP_H = 2'd3
  } grp_t;

  localparam logic [0:2] OP_AND = 3'd0;
  localparam logic [0:2] OP_TAD = 3'd1;
  localparam logic [0:2] OP_ISZ = 3'd2;
  localparam logic [0:2] OP_DCA = 3'd3;
  localparam logic [0:2] OP_JMS = 3'd4;
  localparam logic [0:2] OP_JMP = 3'd5;

  // Major-state group: the upper two encoding bits select F/D/E/H.
  function automatic grp_t state_grp(input state_t s);
    return grp_t'(s[3:2]);
  endfunction

  // Auto-index registers live at page-zero locations 0010-0017 octal.
  function automatic logic is_autoindex(input word_t a);
    return a[0:8] == 9'o001;
  endfunction

endpackage

// File: rtl/pdp8_ma_if.sv
// Sequencer/front-panel side bundle of the memory-address unit.
interface pdp8_ma_if;
  import pdp8_ma_pkg::*;

  state_t state;
  word_t  pc;
  word_t  ac;
  word_t  sr;
  field_t IF;
  field_t DF;
  logic   addr_loadd;
  logic   examd;
  logic   depd;

  word_t  instruction;
  word_t  ma;
  word_t  mdout;
  logic   isz_skip;

  modport master (
    output state, pc, ac, sr, IF, DF, addr_loadd, examd, depd,
    input  instruction, ma, mdout, isz_skip
  );

  modport slave (
    input  state, pc, ac, sr, IF, DF, addr_loadd, examd, depd,
    output instruction, ma, mdout, isz_skip
  );

endinterface

// File: rtl/pdp8_ma_ram.sv
// 32K x 12 core memory: synchronous, read-first, single port.
module pdp8_ma_ram
  import pdp8_ma_pkg::*;
(
  input  logic   clk,
  input  maddr_t addr,
  input  word_t  din,
  input  logic   write_en,
  output word_t  dout
);

  word_t mem [0:MEM_WORDS-1];

  // dout always carries the contents from before any same-cycle write.
  always_ff @(posedge clk) begin
    dout <= mem[addr];
    if (write_en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/pdp8_ma.sv
// PDP-8/e memory-address unit: MA register, instruction register, core
// memory and all reads/writes driven by the major-state sequencer.
module pdp8_ma
  import pdp8_ma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  pdp8_ma_if.slave    bus
);

  word_t  r_ma;
  word_t  r_instruction;
  logic   r_isz_skip;
  logic   r_fp_flag;
  logic   r_rd_valid;

  maddr_t addr;
  word_t  mdin;
  logic   write_en;

  word_t      w_dout;
  word_t      w_mdout;
  word_t      w_md_inc;
  word_t      w_ma_inc;
  logic [0:2] w_opcode;
  logic       w_ind;
  logic       w_cp;
  logic       w_mri;
  logic       w_data_ins;
  logic       w_autoidx;
  grp_t       w_grp;

  assign w_opcode   = r_instruction[0:2];
  assign w_ind      = r_instruction[3];
  assign w_cp       = r_instruction[4];
  assign w_mri      = w_opcode < 3'd6;
  assign w_data_ins = w_opcode <= OP_DCA;
  assign w_autoidx  = is_autoindex(r_ma);
  assign w_grp      = state_grp(bus.state);

  // The RAM output has no reset, so mask it for the cycle following reset.
  assign w_mdout  = r_rd_valid ? w_dout : '0;
  assign w_md_inc = WORD_W'(w_mdout + 12'd1);
  assign w_ma_inc = WORD_W'(r_ma + 12'd1);

  // Memory address: fetch uses the PC, indirect data operands use DF.
  always_comb begin
    addr = {bus.IF, r_ma};
    unique case (w_grp)
      GRP_F:   addr = {bus.IF, bus.pc};
      GRP_E:   addr = (w_data_ins && w_ind) ? {bus.DF, r_ma} : {bus.IF, r_ma};
      default: addr = {bus.IF, r_ma};
    endcase
  end

  // Write strobe and data: auto-index, ISZ/DCA/JMS stores, front-panel deposit.
  always_comb begin
    write_en = 1'b0;
    mdin     = w_mdout;
    case (bus.state)
      D1: begin
        if (w_autoidx) begin
          write_en = 1'b1;
          mdin     = w_md_inc;
        end
      end
      E2: begin
        if (w_opcode == OP_ISZ) begin
          write_en = 1'b1;
          mdin     = w_md_inc;
        end else if (w_opcode == OP_DCA) begin
          write_en = 1'b1;
          mdin     = bus.ac;
        end else if (w_opcode == OP_JMS) begin
          write_en = 1'b1;
          mdin     = bus.pc;
        end
      end
      H1: begin
        if (!bus.addr_loadd && bus.depd) begin
          write_en = 1'b1;
          mdin     = bus.sr;
        end
      end
      default: ;
    endcase
    if (reset) begin
      write_en = 1'b0;
    end
  end

  pdp8_ma_ram ram (
    .clk      (clk),
    .addr     (addr),
    .din      (mdin),
    .write_en (write_en),
    .dout     (w_dout)
  );

  // Register updates per major state; reset overrides every state action.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ma          <= '0;
      r_instruction <= '0;
      r_isz_skip    <= 1'b0;
      r_fp_flag     <= 1'b0;
      r_rd_valid    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b1;
      case (bus.state)
        F0: begin
          r_ma       <= bus.pc;
          r_isz_skip <= 1'b0;
        end
        F1: r_instruction <= w_mdout;
        F2: begin
          if (w_mri) begin
            r_ma <= {w_cp ? r_ma[0:4] : 5'b0, r_instruction[5:11]};
          end
        end
        D2: r_ma <= w_autoidx ? w_md_inc : w_mdout;
        E2: begin
          if (w_opcode == OP_ISZ) begin
            r_isz_skip <= (w_mdout == 12'o7777);
          end
        end
        H0: r_fp_flag <= 1'b0;
        H1: begin
          if (bus.addr_loadd) begin
            r_ma <= bus.sr;
          end else if (bus.depd || bus.examd) begin
            r_fp_flag <= 1'b1;
          end
        end
        H3: begin
          if (r_fp_flag) begin
            r_ma <= w_ma_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.instruction = r_instruction;
  assign bus.ma          = r_ma;
  assign bus.mdout       = w_mdout;
  assign bus.isz_skip    = r_isz_skip;

endmodule

// File: tb/tb_pdp8_ma.sv
// Bench for pdp8_ma: directed instruction table, front-panel and reset
// sequences, and random MRIs checked against an instruction-level model.
module tb_pdp8_ma;
  import pdp8_ma_pkg::*;

  typedef struct packed {
    logic [2:0]  ifld;
    logic [2:0]  dfld;
    logic [11:0] pc;
    logic [11:0] instr;
    logic [11:0] ac;
    logic [11:0] pc_exec;
    logic        has_ptr;
    logic [14:0] ptr_addr;
    logic [11:0] ptr_val;
    logic        has_opnd;
    logic [14:0] opnd_addr;
    logic [11:0] opnd_val;
  } case_t;

  typedef struct packed {
    logic [11:0] instr;
    logic [11:0] ea;
    logic [11:0] fin;
    logic [11:0] md_e;
    logic        skip;
    logic [11:0] mem_opnd;
    logic [11:0] mem_ptr;
  } exp_t;

  typedef struct packed {
    logic [11:0] instr;
    logic [11:0] ea;
    logic [11:0] fin;
    logic [11:0] md_e;
    logic        skip;
    logic        skip_hold;
    logic        skip_clr;
    logic [11:0] mem_opnd;
    logic [11:0] mem_ptr;
  } obs_t;

  typedef struct packed {
    case_t c;
    exp_t  e;
  } vec_t;

  localparam int unsigned NVEC = 11;
  localparam int unsigned NRND = 30;

  logic clk = 1'b0;
  logic reset;
  int   n_err = 0;
  int   n_chk = 0;

  pdp8_ma_if intf ();

  pdp8_ma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %o, expected %o", name, act, exp);
    end
  endtask

  task automatic cyc(input state_t s);
    intf.state = s;
    @(posedge clk);
    #1;
  endtask

  // One front-panel H0..H3 cycle; md is mdout as seen in H2.
  task automatic fp(input logic ld, input logic dp, input logic ex,
                    input logic [11:0] swr, output logic [11:0] md);
    intf.sr = swr;
    cyc(H0);
    intf.addr_loadd = ld;
    intf.depd       = dp;
    intf.examd      = ex;
    cyc(H1);
    md = intf.mdout;
    intf.addr_loadd = 1'b0;
    intf.depd       = 1'b0;
    intf.examd      = 1'b0;
    cyc(H2);
    cyc(H3);
  endtask

  task automatic deposit(input logic [14:0] a, input logic [11:0] v);
    logic [11:0] d;
    intf.IF = a[14:12];
    fp(1'b1, 1'b0, 1'b0, a[11:0], d);
    fp(1'b0, 1'b1, 1'b0, v, d);
  endtask

  task automatic exam(input logic [14:0] a, output logic [11:0] v);
    logic [11:0] d;
    intf.IF = a[14:12];
    fp(1'b1, 1'b0, 1'b0, a[11:0], d);
    fp(1'b0, 1'b0, 1'b1, 12'o0, v);
  endtask

  function automatic case_t mk(
      input logic [2:0] ifld, input logic [2:0] dfld,
      input logic [11:0] pc, input logic [11:0] instr,
      input logic [11:0] ac, input logic [11:0] pc_exec,
      input logic has_ptr, input logic [11:0] ptr_a, input logic [11:0] ptr_val,
      input logic has_opnd, input logic [2:0] opnd_fld,
      input logic [11:0] opnd_a, input logic [11:0] opnd_val);
    case_t c;
    c.ifld      = ifld;
    c.dfld      = dfld;
    c.pc        = pc;
    c.instr     = instr;
    c.ac        = ac;
    c.pc_exec   = pc_exec;
    c.has_ptr   = has_ptr;
    c.ptr_addr  = {ifld, ptr_a};
    c.ptr_val   = ptr_val;
    c.has_opnd  = has_opnd;
    c.opnd_addr = {opnd_fld, opnd_a};
    c.opnd_val  = opnd_val;
    return c;
  endfunction

  function automatic exp_t ex(input logic [11:0] instr, input logic [11:0] ea,
                              input logic [11:0] fin, input logic [11:0] md_e,
                              input logic skip, input logic [11:0] mem_opnd,
                              input logic [11:0] mem_ptr);
    exp_t e;
    e.instr    = instr;
    e.ea       = ea;
    e.fin      = fin;
    e.md_e     = md_e;
    e.skip     = skip;
    e.mem_opnd = mem_opnd;
    e.mem_ptr  = mem_ptr;
    return e;
  endfunction

  // Preload memory, run F (+D if indirect, +E for MRIs), then read back.
  task automatic run_case(input case_t c, output obs_t o);
    logic [2:0] opc;
    logic       ind;
    opc = c.instr[11:9];
    ind = c.instr[8];
    o   = '0;
    if (c.has_ptr)  deposit(c.ptr_addr, c.ptr_val);
    if (c.has_opnd) deposit(c.opnd_addr, c.opnd_val);
    deposit({c.ifld, c.pc}, c.instr);
    intf.IF = c.ifld;
    intf.DF = c.dfld;
    intf.pc = c.pc;
    intf.ac = c.ac;
    cyc(F0);
    cyc(F1);
    o.instr = intf.instruction;
    cyc(F2);
    o.ea = intf.ma;
    cyc(F3);
    if (ind) begin
      cyc(D0);
      cyc(D1);
      cyc(D2);
      o.fin = intf.ma;
      cyc(D3);
    end
    if (opc <= 3'd4) begin
      intf.pc = c.pc_exec;
      cyc(E0);
      cyc(E1);
      o.md_e = intf.mdout;
      cyc(E2);
      o.skip = intf.isz_skip;
      cyc(E3);
      o.skip_hold = intf.isz_skip;
      cyc(F0);
      o.skip_clr = intf.isz_skip;
    end
    if (c.has_ptr)  exam(c.ptr_addr, o.mem_ptr);
    if (c.has_opnd) exam(c.opnd_addr, o.mem_opnd);
  endtask

  task automatic check_case(input string name, input case_t c, input exp_t e, input obs_t o);
    logic [2:0] opc;
    opc = c.instr[11:9];
    chk({name, " instr"}, o.instr, e.instr);
    chk({name, " ea"}, o.ea, e.ea);
    if (c.instr[8]) chk({name, " defer_ma"}, o.fin, e.fin);
    if (opc <= 3'd4) begin
      chk({name, " operand"}, o.md_e, e.md_e);
      chk({name, " skip_e3"}, 12'(o.skip), 12'(e.skip));
      chk({name, " skip_f0"}, 12'(o.skip_hold), 12'(e.skip));
      chk({name, " skip_f1"}, 12'(o.skip_clr), 12'o0);
    end
    if (c.has_ptr)  chk({name, " mem_ptr"}, o.mem_ptr, e.mem_ptr);
    if (c.has_opnd) chk({name, " mem_opnd"}, o.mem_opnd, e.mem_opnd);
  endtask

  // Instruction-level reference: picks a random MRI and predicts its effects.
  task automatic gen_random(output case_t c, output exp_t e);
    logic [2:0]  opc, fi, fd, ofld;
    logic        ind, cp, ai;
    logic [6:0]  off;
    logic [11:0] pc, ea, pv, fin, ov, ac, instr;
    fi  = 3'($urandom_range(0, 7));
    fd  = 3'($urandom_range(0, 7));
    opc = 3'($urandom_range(0, 5));
    ind = 1'($urandom_range(0, 1));
    cp  = 1'($urandom_range(0, 1));
    pc  = 12'($urandom_range(12'o4000, 12'o7576));
    off = 7'($urandom_range(0, 127));
    if (!cp && $urandom_range(0, 2) == 0) off = 7'(8 + $urandom_range(0, 7));
    if (cp && off == pc[6:0]) off = off ^ 7'd1;
    instr = {opc, ind, cp, off};
    ea    = cp ? {pc[11:7], off} : {5'd0, off};
    ai    = ind && ea >= 12'o10 && ea <= 12'o17;
    pv    = 12'($urandom_range(12'o1000, 12'o3776));
    fin   = ind ? (ai ? 12'(pv + 12'd1) : pv) : ea;
    ofld  = (opc <= 3'd3 && ind) ? fd : fi;
    ov    = ($urandom_range(0, 2) == 0) ? 12'o7777 : 12'($urandom);
    ac    = 12'($urandom);
    c = mk(fi, fd, pc, instr, ac, 12'(pc + 12'd1), ind, ea, pv,
           opc <= 3'd4, ofld, fin, ov);
    e = ex(instr, ea, fin, ov, opc == 3'd2 && ov == 12'o7777, ov,
           ai ? 12'(pv + 12'd1) : pv);
    case (opc)
      3'd2:    e.mem_opnd = 12'(ov + 12'd1);
      3'd3:    e.mem_opnd = ac;
      3'd4:    e.mem_opnd = 12'(pc + 12'd1);
      default: e.mem_opnd = ov;
    endcase
  endtask

  initial begin
    vec_t        vecs [NVEC];
    case_t       c;
    exp_t        e;
    obs_t        o;
    logic [11:0] md;

    vecs[0].c  = mk(3'd0, 3'd0, 12'o0200, 12'o5210, 12'o0, 12'o0, 1'b0, 12'o0, 12'o0, 1'b0, 3'd0, 12'o0, 12'o0);
    vecs[0].e  = ex(12'o5210, 12'o0210, 12'o0, 12'o0, 1'b0, 12'o0, 12'o0);
    vecs[1].c  = mk(3'd0, 3'd0, 12'o0300, 12'o5410, 12'o0, 12'o0, 1'b1, 12'o0010, 12'o0227, 1'b0, 3'd0, 12'o0, 12'o0);
    vecs[1].e  = ex(12'o5410, 12'o0010, 12'o0230, 12'o0, 1'b0, 12'o0, 12'o0230);
    vecs[2].c  = mk(3'd0, 3'd0, 12'o0300, 12'o5420, 12'o0, 12'o0, 1'b1, 12'o0020, 12'o0227, 1'b0, 3'd0, 12'o0, 12'o0);
    vecs[2].e  = ex(12'o5420, 12'o0020, 12'o0227, 12'o0, 1'b0, 12'o0, 12'o0227);
    vecs[3].c  = mk(3'd0, 3'd0, 12'o0200, 12'o2250, 12'o0, 12'o0201, 1'b0, 12'o0, 12'o0, 1'b1, 3'd0, 12'o0250, 12'o7777);
    vecs[3].e  = ex(12'o2250, 12'o0250, 12'o0, 12'o7777, 1'b1, 12'o0000, 12'o0);
    vecs[4].c  = mk(3'd0, 3'd0, 12'o0200, 12'o2250, 12'o0, 12'o0201, 1'b0, 12'o0, 12'o0, 1'b1, 3'd0, 12'o0250, 12'o0005);
    vecs[4].e  = ex(12'o2250, 12'o0250, 12'o0, 12'o0005, 1'b0, 12'o0006, 12'o0);
    vecs[5].c  = mk(3'd0, 3'd0, 12'o0200, 12'o3250, 12'o7070, 12'o0201, 1'b0, 12'o0, 12'o0, 1'b1, 3'd0, 12'o0250, 12'o1111);
    vecs[5].e  = ex(12'o3250, 12'o0250, 12'o0, 12'o1111, 1'b0, 12'o7070, 12'o0);
    vecs[6].c  = mk(3'd0, 3'd0, 12'o0300, 12'o4277, 12'o0, 12'o0301, 1'b0, 12'o0, 12'o0, 1'b1, 3'd0, 12'o0277, 12'o0000);
    vecs[6].e  = ex(12'o4277, 12'o0277, 12'o0, 12'o0000, 1'b0, 12'o0301, 12'o0);
    vecs[7].c  = mk(3'd0, 3'd0, 12'o0200, 12'o1250, 12'o0, 12'o0201, 1'b0, 12'o0, 12'o0, 1'b1, 3'd0, 12'o0250, 12'o1234);
    vecs[7].e  = ex(12'o1250, 12'o0250, 12'o0, 12'o1234, 1'b0, 12'o1234, 12'o0);
    vecs[8].c  = mk(3'd1, 3'd2, 12'o0200, 12'o3430, 12'o1357, 12'o0201, 1'b1, 12'o0030, 12'o0400, 1'b1, 3'd2, 12'o0400, 12'o0000);
    vecs[8].e  = ex(12'o3430, 12'o0030, 12'o0400, 12'o0000, 1'b0, 12'o1357, 12'o0400);
    vecs[9].c  = mk(3'd1, 3'd2, 12'o0200, 12'o4430, 12'o0, 12'o0201, 1'b1, 12'o0030, 12'o0500, 1'b1, 3'd1, 12'o0500, 12'o0000);
    vecs[9].e  = ex(12'o4430, 12'o0030, 12'o0500, 12'o0000, 1'b0, 12'o0201, 12'o0500);
    vecs[10].c = mk(3'd3, 3'd5, 12'o0400, 12'o0415, 12'o0, 12'o0401, 1'b1, 12'o0015, 12'o2000, 1'b1, 3'd5, 12'o2001, 12'o4321);
    vecs[10].e = ex(12'o0415, 12'o0015, 12'o2001, 12'o4321, 1'b0, 12'o4321, 12'o2001);

    reset = 1'b1;
    intf.state = H0;
    intf.pc = '0; intf.ac = '0; intf.sr = '0; intf.IF = '0; intf.DF = '0;
    intf.addr_loadd = 1'b0; intf.examd = 1'b0; intf.depd = 1'b0;
    cyc(H0);
    cyc(H0);
    chk("reset ma", intf.ma, 12'o0);
    chk("reset instruction", intf.instruction, 12'o0);
    chk("reset mdout", intf.mdout, 12'o0);
    chk("reset isz_skip", 12'(intf.isz_skip), 12'o0);
    reset = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      run_case(vecs[i].c, o);
      check_case($sformatf("vec%0d", i), vecs[i].c, vecs[i].e, o);
    end

    // Front panel: load, examine, deposit, double examine.
    intf.IF = 3'd0;
    deposit({3'd0, 12'o0007}, 12'o0123);
    fp(1'b1, 1'b0, 1'b0, 12'o0007, md);
    chk("fp load ma", intf.ma, 12'o0007);
    fp(1'b0, 1'b0, 1'b1, 12'o0, md);
    chk("fp exam mdout", md, 12'o0123);
    chk("fp exam ma", intf.ma, 12'o0010);
    fp(1'b0, 1'b1, 1'b0, 12'o0707, md);
    chk("fp dep ma", intf.ma, 12'o0011);
    fp(1'b1, 1'b0, 1'b0, 12'o0007, md);
    fp(1'b0, 1'b0, 1'b1, 12'o0, md);
    chk("fp exam1 mdout", md, 12'o0123);
    fp(1'b0, 1'b0, 1'b1, 12'o0, md);
    chk("fp exam2 mdout", md, 12'o0707);
    chk("fp exam2 ma", intf.ma, 12'o0011);
    fp(1'b0, 1'b0, 1'b0, 12'o0, md);
    chk("fp idle ma", intf.ma, 12'o0011);

    // Priority: load beats deposit beats examine.
    deposit({3'd0, 12'o0050}, 12'o4444);
    fp(1'b1, 1'b1, 1'b1, 12'o0050, md);
    chk("fp prio load ma", intf.ma, 12'o0050);
    exam({3'd0, 12'o0050}, md);
    chk("fp prio no dep", md, 12'o4444);
    fp(1'b1, 1'b0, 1'b0, 12'o0060, md);
    fp(1'b0, 1'b1, 1'b1, 12'o0606, md);
    chk("fp dep+exam ma", intf.ma, 12'o0061);
    exam({3'd0, 12'o0060}, md);
    chk("fp dep+exam mem", md, 12'o0606);

    // Wrap of MA at 7777 on examine.
    fp(1'b1, 1'b0, 1'b0, 12'o7777, md);
    fp(1'b0, 1'b0, 1'b1, 12'o0, md);
    chk("fp wrap ma", intf.ma, 12'o0000);

    for (int i = 0; i < int'(NRND); i++) begin
      gen_random(c, e);
      run_case(c, o);
      check_case($sformatf("rnd%0d", i), c, e, o);
    end

    // Reset in E2 of a DCA: no store, everything cleared.
    deposit({3'd0, 12'o0250}, 12'o1111);
    deposit({3'd0, 12'o0200}, 12'o3250);
    intf.IF = 3'd0;
    intf.DF = 3'd0;
    intf.pc = 12'o0200;
    intf.ac = 12'o7070;
    cyc(F0); cyc(F1); cyc(F2); cyc(F3);
    cyc(E0); cyc(E1);
    intf.state = E2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_e2 ma", intf.ma, 12'o0);
    chk("rst_e2 instruction", intf.instruction, 12'o0);
    chk("rst_e2 mdout", intf.mdout, 12'o0);
    chk("rst_e2 isz_skip", 12'(intf.isz_skip), 12'o0);
    exam({3'd0, 12'o0250}, md);
    chk("rst_e2 no write", md, 12'o1111);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
